// File: rtl/multicycle_control.sv
// Multicycle datapath controller: sequences fetch, decode, memory, ALU and
// branch steps for a small RISC-V style subset (R-type, LD, SD, BEQ).
// Moore controls are registered from the next state so they change cleanly
// on the clock edge. The fetch/branch PC and IR enables are Mealy because
// they depend on mem_ready and zero in the same cycle.
module multicycle_control #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [WIDTH-1:0] instr_count
);

    // Instruction opcodes
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALU operation encodings understood by the datapath ALU
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        TRAP   = 4'd9
    } state_t;

    // Moore control bundle; alu_op is 00 add, 01 sub, 10 decode from funct
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   retire;
    logic   funct7_unused;

    // Only funct7 bit 1 (instruction bit 30) distinguishes SUB/SRA
    assign funct7_unused = funct7[2] ^ funct7[0];

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b10;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state selection from the current step, opcode and memory handshake
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:  if (mem_ready) nxt = DECODE;
            DECODE: begin
                if (opcode == OP_LD || opcode == OP_SD) nxt = MEMADR;
                else if (opcode == OP_RTYPE)            nxt = EXEC;
                else if (opcode == OP_BEQ)              nxt = BRANCH;
                else                                    nxt = TRAP;
            end
            MEMADR: nxt = (opcode == OP_LD) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) nxt = MEMWB;
            MEMWB:  nxt = FETCH;
            MEMWR:  if (mem_ready) nxt = FETCH;
            EXEC:   nxt = ALUWB;
            ALUWB:  nxt = FETCH;
            BRANCH: nxt = FETCH;
            TRAP:   nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end

    // An instruction retires on the cycle it leaves its final step
    assign retire = (cur == MEMWB) || (cur == ALUWB) || (cur == BRANCH) ||
                    ((cur == MEMWR) && mem_ready);

    // State, registered Moore controls, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur         <= FETCH;
            ctrl_q      <= state_ctrl(FETCH);
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            cur    <= nxt;
            ctrl_q <= state_ctrl(nxt);
            if (retire)
                instr_count <= instr_count + WIDTH'(1);
            if (nxt == TRAP)
                illegal <= 1'b1;
        end
    end

    // ALU decoder: fixed add/sub for address and compare, funct-driven for R-type
    always_comb begin
        alu_control = ALU_ADD;
        case (ctrl_q.alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = funct7[1] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7[1] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Enables are forced low while reset is asserted
    assign mem_read   = ctrl_q.mem_read  & rst_n;
    assign mem_write  = ctrl_q.mem_write & rst_n;
    assign reg_write  = ctrl_q.reg_write & rst_n;
    assign ir_write   = rst_n & (cur == FETCH) & mem_ready;
    assign pc_en      = rst_n & (((cur == FETCH) & mem_ready) | ((cur == BRANCH) & zero));
    assign iord       = ctrl_q.iord;
    assign pc_src     = ctrl_q.pc_src;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign state      = cur;

endmodule
